note_recorder: RTL



---
 rtl/piano_pkg.sv | 36 +++
 rtl/key_priority_encoder.sv | 17 +
 rtl/note_recorder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/piano_pkg.sv
// Shared definitions for the song-memory writer (note_recorder) and the playback readers.
// Entry layout, reserved note codes and the default duration tick.
package piano_pkg;

  localparam int unsigned KEY_W   = 7;
  localparam int unsigned OCT_W   = 2;
  localparam int unsigned NOTE_W  = 4;
  localparam int unsigned DUR_W   = 4;
  localparam int unsigned ENTRY_W = OCT_W + NOTE_W + DUR_W;

  localparam int unsigned DUR_LSB  = 0;
  localparam int unsigned NOTE_LSB = DUR_LSB + DUR_W;
  localparam int unsigned OCT_LSB  = NOTE_LSB + NOTE_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'h0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 4'hF;
  localparam logic [DUR_W-1:0]  DUR_MAX   = 4'hF;

  localparam int unsigned TICK_CYCLES_DEF = 6_250_000;

  // One song-memory word, MSB first: {octave, note, duration}
  typedef struct packed {
    logic [OCT_W-1:0]  oct;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REC,
    ST_FLUSH,
    ST_TERM,
    ST_WAIT_LOW
  } rec_state_t;

endpackage

// File: rtl/key_priority_encoder.sv
// Maps the 7 piano keys to a note code: lowest pressed key wins (do=1 .. si=7), none = rest.
module key_priority_encoder
  import piano_pkg::*;
(
  input  logic [KEY_W-1:0]  i_keys,
  output logic [NOTE_W-1:0] o_note_c
);

  // Scan from the top so the lowest set key is the last assignment
  always_comb begin
    o_note_c = NOTE_REST;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (i_keys[i]) o_note_c = NOTE_W'(i + 1);
    end
  end

endmodule

// File: rtl/note_recorder.sv
// Records key presses into song memory as {octave, note, duration} entries,
// closing each take with a terminator entry.
module note_recorder
  import piano_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = TICK_CYCLES_DEF,
  parameter int unsigned ADDR_W      = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_on,
  input  logic [KEY_W-1:0]    keys,
  input  logic [OCT_W-1:0]    octave,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [ENTRY_W-1:0]  wr_data,
  output logic [ADDR_W:0]     rec_len,
  output logic                recording,
  output logic                full
);

  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  // A segment opened by a note change already owns the cycle that opened it
  localparam logic [TICK_W-1:0] OPEN_TICK = TICK_W'((TICK_CYCLES == 1) ? 0 : 1);
  localparam logic [DUR_W-1:0]  OPEN_DUR  = DUR_W'((TICK_CYCLES == 1) ? 1 : 0);

  logic [KEY_W-1:0]  r_keys;
  logic [OCT_W-1:0]  r_oct;
  logic              r_won;
  logic              r_won_prev;

  rec_state_t        r_state, w_nxt_state;
  logic [NOTE_W-1:0] r_cur_note, w_nxt_cur_note;
  logic [OCT_W-1:0]  r_cur_oct, w_nxt_cur_oct;
  logic [DUR_W-1:0]  r_dur, w_nxt_dur;
  logic [TICK_W-1:0] r_tick, w_nxt_tick;
  logic              r_wr_en, w_nxt_wr_en;
  logic              r_wr_inc, w_nxt_wr_inc;
  logic [ADDR_W-1:0] r_wr_addr, w_nxt_wr_addr;
  entry_t            r_wr_data, w_nxt_wr_data;
  logic [LEN_W-1:0]  r_rec_len, w_nxt_rec_len;
  logic              r_full, w_nxt_full;
  logic              r_recording, w_nxt_recording;

  logic [NOTE_W-1:0] w_note;
  logic [ADDR_W-1:0] w_addr;
  logic [LEN_W-1:0]  w_len;
  logic              w_rise;
  logic              w_changed;
  logic              w_wrap;

  key_priority_encoder u_enc (
    .i_keys   (r_keys),
    .o_note_c (w_note)
  );

  // Address and length catch up one cycle after each note write
  assign w_addr    = r_wr_addr + ADDR_W'(r_wr_inc);
  assign w_len     = r_rec_len + LEN_W'(r_wr_inc);
  assign w_rise    = r_won & ~r_won_prev;
  assign w_changed = (w_note != r_cur_note) || (r_oct != r_cur_oct);
  assign w_wrap    = (r_tick == TICK_LAST);

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_cur_note = r_cur_note;
    w_nxt_cur_oct  = r_cur_oct;
    w_nxt_dur      = r_dur;
    w_nxt_tick     = r_tick;
    w_nxt_wr_en    = 1'b0;
    w_nxt_wr_inc   = 1'b0;
    w_nxt_wr_addr  = w_addr;
    w_nxt_wr_data  = r_wr_data;
    w_nxt_rec_len  = w_len;
    w_nxt_full     = r_full;

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_nxt_wr_addr  = '0;
          w_nxt_rec_len  = '0;
          w_nxt_full     = 1'b0;
          w_nxt_cur_note = w_note;
          w_nxt_cur_oct  = r_oct;
          w_nxt_dur      = OPEN_DUR;
          w_nxt_tick     = OPEN_TICK;
          w_nxt_state    = ST_REC;
        end
      end

      ST_REC: begin
        if (!r_won) begin
          w_nxt_state = ST_FLUSH;
        end else if (w_changed || (w_wrap && (r_dur == DUR_MAX))) begin
          // Segments shorter than one tick are dropped as key glitches
          if (r_dur != '0) begin
            if (w_addr == ADDR_MAX) begin
              w_nxt_full  = 1'b1;
              w_nxt_state = ST_TERM;
            end else begin
              w_nxt_wr_en   = 1'b1;
              w_nxt_wr_inc  = 1'b1;
              w_nxt_wr_data = '{oct: r_cur_oct, note: r_cur_note, dur: r_dur};
            end
          end
          w_nxt_cur_note = w_note;
          w_nxt_cur_oct  = r_oct;
          if (w_changed) begin
            w_nxt_dur  = OPEN_DUR;
            w_nxt_tick = OPEN_TICK;
          end else begin
            w_nxt_dur  = '0;
            w_nxt_tick = '0;
          end
        end else if (w_wrap) begin
          w_nxt_tick = '0;
          w_nxt_dur  = r_dur + DUR_W'(1);
        end else begin
          w_nxt_tick = r_tick + TICK_W'(1);
        end
      end

      ST_FLUSH: begin
        if (r_dur != '0) begin
          if (w_addr == ADDR_MAX) begin
            w_nxt_full = 1'b1;
          end else begin
            w_nxt_wr_en   = 1'b1;
            w_nxt_wr_inc  = 1'b1;
            w_nxt_wr_data = '{oct: r_cur_oct, note: r_cur_note, dur: r_dur};
          end
        end
        w_nxt_state = ST_TERM;
      end

      ST_TERM: begin
        w_nxt_wr_en   = 1'b1;
        w_nxt_wr_data = '{oct: '0, note: NOTE_END, dur: '0};
        w_nxt_state   = ST_WAIT_LOW;
      end

      ST_WAIT_LOW: begin
        if (!r_won) w_nxt_state = ST_IDLE;
      end

      default: w_nxt_state = ST_IDLE;
    endcase

    w_nxt_recording = (w_nxt_state == ST_REC) || (w_nxt_state == ST_FLUSH) ||
                      (w_nxt_state == ST_TERM);
  end

  // Previous-switch register resets high so an already-on switch cannot start a take
  always_ff @(posedge clk) begin
    if (reset) begin
      r_keys      <= '0;
      r_oct       <= '0;
      r_won       <= 1'b1;
      r_won_prev  <= 1'b1;
      r_state     <= ST_IDLE;
      r_cur_note  <= NOTE_REST;
      r_cur_oct   <= '0;
      r_dur       <= '0;
      r_tick      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_inc    <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rec_len   <= '0;
      r_full      <= 1'b0;
      r_recording <= 1'b0;
    end else begin
      r_keys      <= keys;
      r_oct       <= octave;
      r_won       <= write_on;
      r_won_prev  <= r_won;
      r_state     <= w_nxt_state;
      r_cur_note  <= w_nxt_cur_note;
      r_cur_oct   <= w_nxt_cur_oct;
      r_dur       <= w_nxt_dur;
      r_tick      <= w_nxt_tick;
      r_wr_en     <= w_nxt_wr_en;
      r_wr_inc    <= w_nxt_wr_inc;
      r_wr_addr   <= w_nxt_wr_addr;
      r_wr_data   <= w_nxt_wr_data;
      r_rec_len   <= w_nxt_rec_len;
      r_full      <= w_nxt_full;
      r_recording <= w_nxt_recording;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign rec_len   = r_rec_len;
  assign recording = r_recording;
  assign full      = r_full;

endmodule
